control_out_gen: RTL and testbench
==================================

// Module: control_out_gen
// PURPOSE
//  Producer side of the 32-bit control_out word that the control_out monitor samples.
//  Decodes each accepted RV32I instruction into the packed control word.
//  Buffers decoded words in a 2-entry skid buffer between fetch (upstream) and execute (downstream).
//  Counts illegal opcodes for debug.
// PARAMETERS
//  CNT_W  8  width of saturating illegal-opcode counter
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst_n        in   1      synchronous reset, active-low
//  in_valid     in   1      in_instr valid
//  in_ready     out  1      block can accept in_instr this cycle
//  in_instr     in   32     raw RV32I instruction word
//  flush        in   1      discard all buffered words (branch mispredict)
//  out_valid    out  1      control_out holds a valid word
//  out_ready    in   1      execute stage consumes control_out
//  control_out  out  32     packed control word (bit[31:0], layout below)
//  illegal_cnt  out  CNT_W  number of illegal opcodes accepted, saturating
// BEHAVIOUR
//  Interface: one clock, clk; reset synchronous active-low, rst_n.
//  Reset (rst_n=0 at edge): state EMPTY, out_valid=0, control_out=0, illegal_cnt=0, in_ready=1.
//  Word layout:
//   [3:0] alu_op        [4] alu_src_imm   [5] reg_write   [6] mem_read
//   [7] mem_write       [8] mem_to_reg    [9] branch      [10] jump
//   [13:11] funct3      [18:14] rd=instr[11:7]            [23:19] rs1=instr[19:15]
//   [28:24] rs2=instr[24:20]              [30:29] 0       [31] illegal
//  alu_op encoding: ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SRA7 SLT8 SLTU9 PASSB10.
//  Decode by opcode (funct3 field always = instr[14:12]):
//   0110011 R     : reg_write; alu_op from funct3 and instr[30] (SUB, SRA).
//   0010011 I-ALU : reg_write, alu_src_imm; same mapping, but instr[30] is used only for SRAI.
//   0000011 LOAD  : ADD, alu_src_imm, reg_write, mem_read, mem_to_reg.
//   0100011 STORE : ADD, alu_src_imm, mem_write.
//   1100011 BRANCH: SUB, branch.
//   1101111 JAL, 1100111 JALR: ADD, reg_write, jump; JALR also alu_src_imm.
//   0110111 LUI   : PASSB, alu_src_imm, reg_write.
//   0010111 AUIPC : ADD, alu_src_imm, reg_write.
//   Any other opcode: word = 32'h8000_0000 (only bit31 set).
//  Buffer states: EMPTY, ONE, TWO (occupancy). out_valid = (state != EMPTY).
//  in_ready = (state != TWO), registered from state.
//  push = in_valid & in_ready & ~flush.  pop = out_valid & out_ready.
//   EMPTY: push -> ONE.
//   ONE  : push&~pop -> TWO; pop&~push -> EMPTY; push&pop -> stays ONE, head replaced by new word.
//   TWO  : pop -> ONE, second entry becomes head; no push is possible.
//  Latency: instruction pushed at edge N appears on control_out after edge N (same cycle as head if buffer was EMPTY).
//  Ordering is strict FIFO. control_out is stable while out_valid=1 and out_ready=0.
//  When state is EMPTY, control_out holds its last value; checkers ignore it while out_valid=0.
//  flush=1: next state EMPTY, same-cycle input dropped, same-cycle pop still counts as consumed.
//   in_ready=1 on the following cycle.
//  illegal_cnt increments once per pushed illegal word, saturates at 2^CNT_W-1, is not cleared by flush.
//  Reset mid-operation overrides flush and handshakes; all buffered words are lost.
// TESTING
//  add x3,x1,x2 (0x002081B3), out_ready=1 -> control_out=0x0208C020, out_valid one cycle.
//  lw x5,8(x2) (0x00812283) -> control_out=0x08115170.
//  in_instr=0xFFFFFFFF -> control_out=0x80000000, illegal_cnt 0->1; 300 illegals with CNT_W=8 -> 255.
//  out_ready=0, push A,B,C back-to-back -> in_ready=0 after B, C held;
//   then out_ready=1 -> A,B,C out in order, with no duplicate or loss.
//  State TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped instr never appears.
//  rst_n=0 for one edge while in TWO -> out_valid=0, illegal_cnt=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/control_out_gen.sv
// RV32I control-word decoder feeding a 2-entry skid buffer toward execute.
// Also keeps a saturating count of accepted illegal opcodes for debug.
module control_out_gen #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      control_out,
  output logic [CNT_W-1:0] illegal_cnt
);

  // state | meaning
  // EMPTY | no buffered word, control_out is stale
  // ONE   | head word valid on control_out
  // TWO   | head plus one queued word, input stalled
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t      state, state_nxt;
  logic [31:0] slot1;
  logic [31:0] dec_word;
  logic        push, pop;
  logic        load_head, load_slot1, head_from_slot1;

  logic [3:0]  alu_op;
  logic        alu_src_imm, reg_write, mem_read, mem_write, mem_to_reg;
  logic        branch, jump, illegal, alt;
  logic [2:0]  funct3;
  logic        unused_instr;

  assign funct3       = in_instr[14:12];
  assign unused_instr = ^{in_instr[31], in_instr[29:25]};

  always_comb begin
    alu_op      = 4'd0;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_to_reg  = 1'b0;
    branch      = 1'b0;
    jump        = 1'b0;
    illegal     = 1'b0;
    alt         = 1'b0;
    case (in_instr[6:0])
      7'b0110011: begin reg_write = 1'b1; alt = in_instr[30]; end
      // immediates reuse bit 30 as data except for the SRAI shift form
      7'b0010011: begin
        reg_write   = 1'b1;
        alu_src_imm = 1'b1;
        alt         = in_instr[30] & (funct3 == 3'b101);
      end
      7'b0000011: begin alu_src_imm = 1'b1; reg_write = 1'b1; mem_read = 1'b1; mem_to_reg = 1'b1; end
      7'b0100011: begin alu_src_imm = 1'b1; mem_write = 1'b1; end
      7'b1100011: begin alu_op = 4'd1; branch = 1'b1; end
      7'b1101111: begin reg_write = 1'b1; jump = 1'b1; end
      7'b1100111: begin reg_write = 1'b1; jump = 1'b1; alu_src_imm = 1'b1; end
      7'b0110111: begin alu_op = 4'd10; alu_src_imm = 1'b1; reg_write = 1'b1; end
      7'b0010111: begin alu_src_imm = 1'b1; reg_write = 1'b1; end
      default:    illegal = 1'b1;
    endcase
    if (in_instr[6:0] == 7'b0110011 || in_instr[6:0] == 7'b0010011) begin
      case (funct3)
        3'b000:  alu_op = alt ? 4'd1 : 4'd0;
        3'b001:  alu_op = 4'd5;
        3'b010:  alu_op = 4'd8;
        3'b011:  alu_op = 4'd9;
        3'b100:  alu_op = 4'd4;
        3'b101:  alu_op = alt ? 4'd7 : 4'd6;
        3'b110:  alu_op = 4'd3;
        default: alu_op = 4'd2;
      endcase
    end
    if (illegal)
      dec_word = 32'h8000_0000;
    else
      dec_word = {1'b0, 2'b00, in_instr[24:20], in_instr[19:15], in_instr[11:7], funct3,
                  jump, branch, mem_to_reg, mem_write, mem_read, reg_write, alu_src_imm, alu_op};
  end

  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_nxt       = state;
    load_head       = 1'b0;
    load_slot1      = 1'b0;
    head_from_slot1 = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (push) begin state_nxt = ONE; load_head = 1'b1; end
        ONE: begin
          if (push && pop) load_head = 1'b1;
          else if (push) begin state_nxt = TWO; load_slot1 = 1'b1; end
          else if (pop) state_nxt = EMPTY;
        end
        TWO: if (pop) begin state_nxt = ONE; head_from_slot1 = 1'b1; end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= EMPTY;
      control_out <= 32'd0;
      slot1       <= 32'd0;
      illegal_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (load_head)       control_out <= dec_word;
      if (head_from_slot1) control_out <= slot1;
      if (load_slot1)      slot1       <= dec_word;
      if (push && illegal && illegal_cnt != {CNT_W{1'b1}})
        illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_control_out_gen.sv
// Directed and randomized checks of control_out_gen against a queue-based
// reference model with an independent arithmetic decoder.
module tb_control_out_gen;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]      in_instr, control_out;
  logic [CNT_W-1:0] illegal_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] mq[$];
  logic [31:0] popped[$];
  int          mcnt = 0;
  int          alu_of_f3[8] = '{0, 5, 8, 9, 4, 6, 3, 2};
  logic [6:0]  ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_LW  = 32'h00812283;
  localparam logic [31:0] I_BAD = 32'hFFFFFFFF;
  localparam logic [31:0] I_LUI = 32'h123453B7;

  always #5 clk = ~clk;

  control_out_gen #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .control_out(control_out), .illegal_cnt(illegal_cnt)
  );

  function automatic logic [31:0] ref_word(input logic [31:0] i);
    int f3, alu, imm, rw, mr, mw, m2r, br, jp;
    f3 = int'(i[14:12]);
    alu = 0; imm = 0; rw = 0; mr = 0; mw = 0; m2r = 0; br = 0; jp = 0;
    case (i[6:0])
      7'h33: begin
        rw = 1; alu = alu_of_f3[f3];
        if (i[30] && f3 == 0) alu = 1;
        if (i[30] && f3 == 5) alu = 7;
      end
      7'h13: begin
        rw = 1; imm = 1; alu = alu_of_f3[f3];
        if (i[30] && f3 == 5) alu = 7;
      end
      7'h03: begin imm = 1; rw = 1; mr = 1; m2r = 1; end
      7'h23: begin imm = 1; mw = 1; end
      7'h63: begin alu = 1; br = 1; end
      7'h6F: begin rw = 1; jp = 1; end
      7'h67: begin rw = 1; jp = 1; imm = 1; end
      7'h37: begin alu = 10; imm = 1; rw = 1; end
      7'h17: begin imm = 1; rw = 1; end
      default: return 32'h8000_0000;
    endcase
    return 32'(alu + imm*16 + rw*32 + mr*64 + mw*128 + m2r*256 + br*512 + jp*1024
              + f3*2048 + int'(i[11:7])*(1<<14) + int'(i[19:15])*(1<<19)
              + int'(i[24:20])*(1<<24));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
    bit          push, pop;
    logic [31:0] w;
    in_valid = v; in_instr = ins; out_ready = rdy; flush = fl;
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
    chk("in_ready", {31'd0, in_ready}, (mq.size() < 2) ? 32'd1 : 32'd0);
    chk("illegal_cnt", 32'(illegal_cnt), 32'(mcnt));
    if (mq.size() != 0) chk("control_out", control_out, mq[0]);
    if (out_valid && rdy) popped.push_back(control_out);
    w    = ref_word(ins);
    push = v && (mq.size() < 2) && !fl;
    pop  = (mq.size() != 0) && rdy;
    if (fl) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(w);
    end
    if (push && w == 32'h8000_0000 && mcnt < (1 << CNT_W) - 1) mcnt++;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] exp_seq[3];
    logic [31:0] obs, r;
    bit          seen;
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; out_ready = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_control_out", control_out, 32'd0);
    chk("rst_illegal_cnt", 32'(illegal_cnt), 32'd0);

    step(1, I_ADD, 1, 0);
    chk("add_word", control_out, 32'h0208C020);
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    step(0, 0, 1, 0);
    chk("add_one_cycle", {31'd0, out_valid}, 32'd0);
    step(1, I_LW, 1, 0);
    chk("lw_word", control_out, 32'h08115170);
    step(0, 0, 1, 0);
    step(1, I_BAD, 1, 0);
    chk("illegal_word", control_out, 32'h8000_0000);
    chk("illegal_cnt_1", 32'(illegal_cnt), 32'd1);
    step(0, 0, 1, 0);

    popped.delete();
    step(1, I_ADD, 0, 0);
    step(1, I_LW, 0, 0);
    chk("in_ready_after_b", {31'd0, in_ready}, 32'd0);
    step(1, I_BAD, 0, 0);
    step(1, I_BAD, 0, 0);
    chk("head_held", control_out, 32'h0208C020);
    step(1, I_BAD, 1, 0);
    step(1, I_BAD, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    exp_seq = '{32'h0208C020, 32'h08115170, 32'h8000_0000};
    chk("abc_count", 32'(popped.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      obs = (k < popped.size()) ? popped[k] : 32'hDEADBEEF;
      chk($sformatf("abc_order_%0d", k), obs, exp_seq[k]);
    end

    popped.delete();
    step(1, I_ADD, 0, 0);
    step(1, I_LW, 0, 0);
    step(1, I_LUI, 0, 1);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (3) step(0, 0, 1, 0);
    seen = 1'b0;
    foreach (popped[k]) if (popped[k] == ref_word(I_LUI)) seen = 1'b1;
    chk("flush_dropped", {31'd0, seen}, 32'd0);

    repeat (300) step(1, I_BAD, 1, 0);
    step(0, 0, 1, 0);
    chk("illegal_saturate", 32'(illegal_cnt), 32'd255);

    step(1, I_ADD, 0, 0);
    step(1, I_LW, 0, 0);
    rst_n = 1'b0; in_valid = 1'b1; in_instr = I_BAD; out_ready = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid = 1'b0;
    mq.delete(); mcnt = 0;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_illegal_cnt", 32'(illegal_cnt), 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int n = 0; n < 1500; n++) begin
      r = $urandom;
      r[6:0] = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 0) r[6:0] = 7'($urandom);
      step($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
